// File: rtl/pc_branch_ctrl.sv
// Program counter, ALU flag registers and run/halt sequencing for the core.
// Optional build macro FLAG_FWD_EN: conditional branches see same-cycle ALU flags.
module pc_branch_ctrl #(
  parameter int unsigned PC_W       = 10,
  parameter int unsigned START_ADDR = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  input  logic            halt_req,
  input  logic [1:0]      br_kind,
  input  logic            br_abs,
  input  logic [PC_W-1:0] br_target,
  input  logic [7:0]      br_off,
  input  logic            flag_we,
  input  logic            alu_co,
  input  logic            alu_z,
  input  logic            alu_neg,
  output logic [PC_W-1:0] pc,
  output logic            ci_q,
  output logic            z_q,
  output logic            neg_q,
  output logic            running,
  output logic            done,
  output logic            branch_taken
);

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_JMP  = 2'd1;
  localparam logic [1:0] BR_BRN  = 2'd2;
  localparam logic [1:0] BR_BRZ  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e            state_q;
  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   pc_d;
  logic [PC_W-1:0]   off_ext;
  logic signed [7:0] off_s;
  logic              n_c;
  logic              z_c;
  logic              taken_c;

  assign off_s   = $signed(br_off);
  assign off_ext = PC_W'(off_s);

  // Branch condition flags, optionally bypassed from the ALU in the write cycle
  always_comb begin
    n_c = neg_q;
    z_c = z_q;
`ifdef FLAG_FWD_EN
    if (flag_we) begin
      n_c = alu_neg;
      z_c = alu_z;
    end
`endif
    case (br_kind)
      BR_NONE: taken_c = 1'b0;
      BR_JMP:  taken_c = 1'b1;
      BR_BRN:  taken_c = n_c;
      BR_BRZ:  taken_c = z_c;
      default: taken_c = 1'b0;
    endcase
  end

  // Next PC in RUN; relative targets and sequential advance both wrap mod 2^PC_W
  always_comb begin
    pc_d = pc_q + PC_W'(1);
    if (taken_c) begin
      if (br_abs) begin
        pc_d = br_target;
      end else begin
        pc_d = pc_q + off_ext;
      end
    end
  end

  // Run/halt sequencing, PC and flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= START_PC;
      ci_q         <= 1'b0;
      z_q          <= 1'b0;
      neg_q        <= 1'b0;
      branch_taken <= 1'b0;
    end else begin
      branch_taken <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RUN;
            pc_q    <= START_PC;
          end
        end
        S_RUN: begin
          if (!stall) begin
            if (halt_req) begin
              state_q <= S_HALT;
            end else begin
              pc_q         <= pc_d;
              branch_taken <= taken_c;
              if (flag_we) begin
                ci_q  <= alu_co;
                z_q   <= alu_z;
                neg_q <= alu_neg;
              end
            end
          end
        end
        S_HALT: begin
          if (start) begin
            state_q <= S_RUN;
            pc_q    <= START_PC;
            ci_q    <= 1'b0;
            z_q     <= 1'b0;
            neg_q   <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pc      = pc_q;
  assign running = (state_q == S_RUN);
  assign done    = (state_q == S_HALT);

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Self-checking bench for pc_branch_ctrl: directed scenarios plus randomized
// traffic compared every cycle against an arithmetic reference model.
module tb_pc_branch_ctrl;

  localparam int unsigned PC_W = 10;
  localparam int MOD = 1 << PC_W;

`ifdef FLAG_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            stall = 1'b0;
  logic            halt_req = 1'b0;
  logic [1:0]      br_kind = 2'd0;
  logic            br_abs = 1'b0;
  logic [PC_W-1:0] br_target = '0;
  logic [7:0]      br_off = 8'd0;
  logic            flag_we = 1'b0;
  logic            alu_co = 1'b0;
  logic            alu_z = 1'b0;
  logic            alu_neg = 1'b0;
  logic [PC_W-1:0] pc;
  logic            ci_q;
  logic            z_q;
  logic            neg_q;
  logic            running;
  logic            done;
  logic            branch_taken;

  pc_branch_ctrl #(.PC_W(PC_W), .START_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt_req(halt_req),
    .br_kind(br_kind), .br_abs(br_abs), .br_target(br_target), .br_off(br_off),
    .flag_we(flag_we), .alu_co(alu_co), .alu_z(alu_z), .alu_neg(alu_neg),
    .pc(pc), .ci_q(ci_q), .z_q(z_q), .neg_q(neg_q), .running(running),
    .done(done), .branch_taken(branch_taken)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Reference model: 0=idle, 1=run, 2=halt
  int m_state = 0;
  int m_pc    = 0;
  int m_ci    = 0;
  int m_z     = 0;
  int m_n     = 0;
  int m_bt    = 0;

  always @(posedge clk or posedge reset) begin
    int nn, zz, tk, off;
    if (reset) begin
      m_state = 0; m_pc = 0; m_ci = 0; m_z = 0; m_n = 0; m_bt = 0;
    end else begin
      m_bt = 0;
      if (m_state == 0) begin
        if (start) begin m_state = 1; m_pc = 0; end
      end else if (m_state == 2) begin
        if (start) begin m_state = 1; m_pc = 0; m_ci = 0; m_z = 0; m_n = 0; end
      end else if (!stall) begin
        if (halt_req) begin
          m_state = 2;
        end else begin
          nn = m_n;
          zz = m_z;
          if (FWD && flag_we) begin nn = int'(alu_neg); zz = int'(alu_z); end
          tk = (br_kind == 2'd1) || (br_kind == 2'd2 && nn != 0) || (br_kind == 2'd3 && zz != 0);
          off = (int'(br_off) >= 128) ? int'(br_off) - 256 : int'(br_off);
          if (tk != 0) begin
            if (br_abs) m_pc = int'(br_target);
            else        m_pc = (m_pc + off + MOD) % MOD;
          end else begin
            m_pc = (m_pc + 1) % MOD;
          end
          m_bt = tk;
          if (flag_we) begin m_ci = int'(alu_co); m_z = int'(alu_z); m_n = int'(alu_neg); end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("pc",           int'(pc),           m_pc);
    chk("ci_q",         int'(ci_q),         m_ci);
    chk("z_q",          int'(z_q),          m_z);
    chk("neg_q",        int'(neg_q),        m_n);
    chk("running",      int'(running),      int'(m_state == 1));
    chk("done",         int'(done),         int'(m_state == 2));
    chk("branch_taken", int'(branch_taken), m_bt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    start = 0; stall = 0; halt_req = 0; br_kind = 0; br_abs = 0; br_target = '0;
    br_off = 0; flag_we = 0; alu_co = 0; alu_z = 0; alu_neg = 0;
  endtask

  initial begin
    int p;
    clr();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_pc", int'(pc), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_done", int'(done), 0);

    // Start then free-running sequence
    start = 1; tick(); clr();
    chk("start_pc", int'(pc), 0);
    chk("start_running", int'(running), 1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("seq_pc", int'(pc), i);
    end
    chk("seq_done", int'(done), 0);

    // Relative backward jump from 20
    br_kind = 1; br_abs = 1; br_target = 10'd20; tick();
    chk("jmp_abs20", int'(pc), 20);
    br_kind = 1; br_abs = 0; br_off = 8'hFC; tick();
    chk("jmp_rel_pc", int'(pc), 16);
    chk("model_pc16", m_pc, 16);
    chk("jmp_rel_bt", int'(branch_taken), 1);
    clr(); tick();
    chk("after_jmp_pc", int'(pc), 17);
    chk("bt_pulse_end", int'(branch_taken), 0);

    // Wrap at top of address space
    br_kind = 1; br_abs = 1; br_target = 10'd1023; tick(); clr(); tick();
    chk("wrap_pc", int'(pc), 0);
    br_kind = 1; br_abs = 1; br_target = 10'd2; tick();
    br_abs = 0; br_off = 8'hFB; tick(); clr();
    chk("rel_wrap_pc", int'(pc), 1021);
    chk("model_pc1021", m_pc, 1021);

    // Flag write followed by BRZ
    flag_we = 1; alu_z = 1; tick(); clr();
    chk("z_set", int'(z_q), 1);
    br_kind = 3; br_abs = 1; br_target = 10'd100; tick(); clr();
    chk("brz_next", int'(pc), 100);
    flag_we = 1; alu_z = 0; tick();
    chk("z_clear", int'(z_q), 0);
    flag_we = 1; alu_z = 1; br_kind = 3; br_abs = 1; br_target = 10'd100; tick(); clr();
    chk("brz_same", int'(pc), FWD ? 100 : 102);

    // Stall dominates halt/branch/flags; then halt beats branch
    flag_we = 1; alu_neg = 1; tick(); clr();
    p = int'(pc);
    stall = 1; halt_req = 1; br_kind = 2; br_abs = 1; br_target = 10'd500;
    flag_we = 1; alu_neg = 0; alu_z = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", int'(pc), p);
      chk("stall_neg", int'(neg_q), 1);
      chk("stall_bt", int'(branch_taken), 0);
    end
    stall = 0; tick(); clr();
    chk("halt_done", int'(done), 1);
    chk("halt_pc", int'(pc), p);
    chk("halt_neg", int'(neg_q), 1);
    start = 1; tick(); clr();
    chk("restart_pc", int'(pc), 0);
    chk("restart_done", int'(done), 0);
    chk("restart_neg", int'(neg_q), 0);

    // Async reset mid-RUN
    flag_we = 1; alu_co = 1; alu_z = 1; alu_neg = 1; br_kind = 1; br_abs = 1;
    br_target = 10'd37; tick(); clr();
    chk("pre_rst_pc", int'(pc), 37);
    chk("pre_rst_ci", int'(ci_q), 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_pc", int'(pc), 0);
    chk("arst_ci", int'(ci_q), 0);
    chk("arst_z", int'(z_q), 0);
    chk("arst_running", int'(running), 0);
    tick(); reset = 1'b0;
    halt_req = 1; br_kind = 1; br_abs = 1; br_target = 10'd300; flag_we = 1; alu_z = 1;
    tick(); clr();
    chk("idle_ignore_pc", int'(pc), 0);
    chk("idle_ignore_z", int'(z_q), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(0, 9) == 0);
      stall     = ($urandom_range(0, 4) == 0);
      halt_req  = ($urandom_range(0, 39) == 0);
      br_kind   = 2'($urandom_range(0, 3));
      br_abs    = 1'($urandom_range(0, 1));
      br_target = PC_W'($urandom);
      br_off    = 8'($urandom);
      flag_we   = 1'($urandom_range(0, 1));
      alu_co    = 1'($urandom_range(0, 1));
      alu_z     = 1'($urandom_range(0, 1));
      alu_neg   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b1;
        #1 reset = 1'b0;
      end
      tick();
    end
    clr();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pc_branch_ctrl.md
Name: pc_branch_ctrl

Overview:
Program counter and branch-resolution stage that sits directly downstream of the ALU. It registers the ALU status flags (co, z, neg) and feeds the registered carry back to the ALU carry-in. Each cycle it uses the decoded branch controls and the flags to pick the next PC. It also owns the run/halt sequencing of the core: start handshake, stall hold, and done indication.

Parameters:
PC_W, 10, width of program counter / instruction address
START_ADDR, 0, PC value loaded on reset and on every start

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  begin program; honoured in IDLE and HALT only
stall  in  1  hold PC and flags this cycle (RUN only)
halt_req  in  1  decoded halt instruction
br_kind  in  2  0=none, 1=JMP unconditional, 2=BRN if neg, 3=BRZ if zero
br_abs  in  1  1: absolute target; 0: PC-relative offset
br_target  in  PC_W  absolute branch target
br_off  in  8  signed two's-complement relative offset
flag_we  in  1  capture ALU flags this cycle
alu_co  in  1  ALU carry out
alu_z  in  1  ALU zero flag
alu_neg  in  1  ALU negative flag
pc  out  PC_W  current instruction address
ci_q  out  1  registered carry, drives ALU ci
z_q  out  1  registered zero flag
neg_q  out  1  registered negative flag
running  out  1  high while in RUN
done  out  1  high while in HALT
branch_taken  out  1  registered one-cycle pulse after a taken branch

Behaviour:
- Reset (async, any state, mid-program included): state=IDLE, pc=START_ADDR, ci_q=z_q=neg_q=0, running=0, done=0, branch_taken=0.
- States: IDLE, RUN, HALT. running=(state==RUN), done=(state==HALT), both decoded from registered state.
- IDLE: start=1 -> RUN and pc=START_ADDR. All other inputs are ignored.
- RUN with stall=1: pc, flags, state hold; branch_taken=0 next cycle. Stall overrides halt_req, branch and flag_we.
- RUN with stall=0, priority order:
  1. halt_req=1 -> HALT. pc holds, flags do not update, branch is ignored.
  2. Otherwise taken = (br_kind==1) | (br_kind==2 & N) | (br_kind==3 & Z).
     - N and Z are neg_q and z_q. See FLAG_FWD_EN for the bypass variant.
     - taken & br_abs: pc <= br_target.
     - taken & !br_abs: pc <= pc + sign_extend(br_off) modulo 2^PC_W. The result wraps; there is no saturation.
     - not taken: pc <= pc+1, wrapping from 2^PC_W-1 to 0.
  3. flag_we=1: ci_q<=alu_co, z_q<=alu_z, neg_q<=alu_neg. This happens in the same edge as the PC update and is independent of branching.
- branch_taken <= taken, qualified by RUN & !stall & !halt_req. It is a 1-cycle pulse per taken branch.
- start while in RUN is ignored.
- HALT: pc and flags hold, done=1. start=1 -> RUN, pc=START_ADDR, flags cleared to 0; done drops on the same edge.
- PC latency: the PC update is visible one cycle after inputs are sampled. There is no delay slot.

Optional Feature:
FLAG_FWD_EN
- Defined: when flag_we=1 in the same cycle as a conditional branch, N/Z are taken from alu_neg/alu_z (combinational bypass), so a compare and a branch may share a cycle.
- Undefined: branches always use registered neg_q/z_q. Same-cycle flag writes affect only the next branch.
- Flag register update is identical in both builds.

Test Plan:
- Reset then start pulse, 5 free cycles -> pc sequence 0,1,2,3,4,5; running=1; done=0.
- RUN at pc=20, br_kind=1, br_abs=0, br_off=8'hFC -> pc=16 next cycle; branch_taken pulses once.
- pc=1023 (PC_W=10), no branch -> pc=0. Also at pc=2, br_off=-5 -> pc=1021.
- flag_we with alu_z=1 at cycle N, then BRZ br_abs=1 br_target=100 at N+1 -> pc=100. BRZ at cycle N itself -> pc+1 without FLAG_FWD_EN, pc=100 with it.
- stall=1 for 3 cycles during BRN with neg_q=1 plus halt_req -> pc, flags and state unchanged, branch_taken=0. On release, HALT is entered (halt beats branch), done=1, pc unchanged.
- Assert reset mid-RUN at pc=37 with flags set -> immediately pc=0, flags 0, IDLE. start in HALT -> pc=0, RUN, done=0.
